// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone classic-cycle master.
// Takes one core request, runs one bus cycle, returns data/error on a
// one-cycle response pulse, then holds stb low for one recovery cycle.
// Optional: define WB_MASTER_TIMEOUT_EN to abort silent cycles after
// TIMEOUT bus cycles and report them on rsp_timeout_o.
module wb_master #(
  parameter int ADR_WIDTH = 64,
  parameter int DAT_WIDTH = 64,
  parameter int GRANULE   = 8,
  parameter int SEL_WIDTH = DAT_WIDTH / GRANULE,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADR_WIDTH-1:0] req_adr_i,
  input  logic [DAT_WIDTH-1:0] req_dat_i,
  input  logic [SEL_WIDTH-1:0] req_sel_i,
  output logic                 rsp_valid_o,
  output logic [DAT_WIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADR_WIDTH-1:0] mst_adr_o,
  output logic [DAT_WIDTH-1:0] mst_dat_o,
  input  logic [DAT_WIDTH-1:0] mst_dat_i,
  output logic                 mst_we_o,
  output logic [SEL_WIDTH-1:0] mst_sel_o,
  output logic                 mst_cyc_o,
  output logic                 mst_stb_o,
  input  logic                 mst_ack_i,
  input  logic                 mst_err_i
`ifdef WB_MASTER_TIMEOUT_EN
  ,
  output logic                 rsp_timeout_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUS, RECOVER} state_t;

  // Low address bits that must be zero for a full-word access.
  localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ADR_WIDTH'((DAT_WIDTH / 8) - 1);

  state_t                 r_state, w_state_nxt;
  logic                   r_ready, w_ready_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic [DAT_WIDTH-1:0]   r_rsp_dat, w_rsp_dat_nxt;
  logic                   r_rsp_err, w_rsp_err_nxt;
  logic [ADR_WIDTH-1:0]   r_adr, w_adr_nxt;
  logic [DAT_WIDTH-1:0]   r_dat, w_dat_nxt;
  logic                   r_we, w_we_nxt;
  logic [SEL_WIDTH-1:0]   r_sel, w_sel_nxt;
  logic                   r_cyc, w_cyc_nxt;
  logic                   w_misaligned;
`ifdef WB_MASTER_TIMEOUT_EN
  logic [7:0]             r_cnt, w_cnt_nxt;
  logic                   r_rsp_to, w_rsp_to_nxt;
`endif

  assign w_misaligned = |(req_adr_i & ALIGN_MASK);

  // Next-state and next-output decode; every output is taken from a register.
  always_comb begin
    w_state_nxt     = r_state;
    w_ready_nxt     = r_ready;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_cyc_nxt       = r_cyc;
`ifdef WB_MASTER_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
    w_rsp_to_nxt    = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (req_valid_i && r_ready) begin
          w_ready_nxt = 1'b0;
          if (w_misaligned) begin
            // Rejected locally: the bus never sees this request.
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_dat_nxt   = '0;
            w_state_nxt     = RECOVER;
          end else begin
            w_adr_nxt   = req_adr_i;
            w_dat_nxt   = req_dat_i;
            w_we_nxt    = req_we_i;
            w_sel_nxt   = req_sel_i;
            w_cyc_nxt   = 1'b1;
            w_state_nxt = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end
        end
      end
      BUS: begin
        if (mst_err_i) begin
          // err wins over a simultaneous ack.
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_dat_nxt   = '0;
          w_cyc_nxt       = 1'b0;
          w_state_nxt     = RECOVER;
        end else if (mst_ack_i) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_dat_nxt   = r_we ? '0 : mst_dat_i;
          w_cyc_nxt       = 1'b0;
          w_state_nxt     = RECOVER;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (r_cnt == 8'(TIMEOUT)) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_dat_nxt   = '0;
          w_rsp_to_nxt    = 1'b1;
          w_cyc_nxt       = 1'b0;
          w_state_nxt     = RECOVER;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      RECOVER: begin
        // One cycle of stb low before the core may issue again.
        w_ready_nxt = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_ready_nxt = 1'b1;
        w_cyc_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops cyc/stb asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_cyc       <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_to    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_cyc       <= w_cyc_nxt;
`ifdef WB_MASTER_TIMEOUT_EN
      r_cnt       <= w_cnt_nxt;
      r_rsp_to    <= w_rsp_to_nxt;
`endif
    end
  end

  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign mst_adr_o   = r_adr;
  assign mst_dat_o   = r_dat;
  assign mst_we_o    = r_we;
  assign mst_sel_o   = r_sel;
  // Classic single cycles: stb always tracks cyc.
  assign mst_cyc_o   = r_cyc;
  assign mst_stb_o   = r_cyc;
`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_timeout_o = r_rsp_to;
`endif

endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: directed bench for wb_master against a small ROM slave model.
module tb_wb_master;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [63:0] req_adr_i = '0;
  logic [63:0] req_dat_i = '0;
  logic [7:0]  req_sel_i = '0;
  logic        rsp_valid_o;
  logic [63:0] rsp_dat_o;
  logic        rsp_err_o;
  logic [63:0] mst_adr_o;
  logic [63:0] mst_dat_o;
  logic [63:0] mst_dat_i;
  logic        mst_we_o;
  logic [7:0]  mst_sel_o;
  logic        mst_cyc_o;
  logic        mst_stb_o;
  logic        mst_ack_i;
  logic        mst_err_i;
`ifdef WB_MASTER_TIMEOUT_EN
  logic        rsp_timeout_o;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int mode = 0; // 0 ROM, 1 ack+err together, 2 silent

  always #5 clk_i = ~clk_i;

  wb_master #(.ADR_WIDTH(64), .DAT_WIDTH(64), .GRANULE(8), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .mst_adr_o(mst_adr_o), .mst_dat_o(mst_dat_o), .mst_dat_i(mst_dat_i),
    .mst_we_o(mst_we_o), .mst_sel_o(mst_sel_o), .mst_cyc_o(mst_cyc_o),
    .mst_stb_o(mst_stb_o), .mst_ack_i(mst_ack_i), .mst_err_i(mst_err_i)
`ifdef WB_MASTER_TIMEOUT_EN
    , .rsp_timeout_o(rsp_timeout_o)
`endif
  );

  // Read-only ROM slave: registered one-cycle ack on reads, err on writes.
  function automatic logic [63:0] rom_f(input logic [63:0] a);
    case (a[5:3])
      3'd0:    rom_f = 64'h0280401002000010;
      3'd1:    rom_f = 64'h0280800000000e60;
      3'd2:    rom_f = 64'h0281000000000060;
      default: rom_f = 64'hdeadbeefdeadbeef;
    endcase
  endfunction

  logic s_ack = 1'b0, s_err = 1'b0;
  always @(posedge clk_i) begin
    s_ack <= 1'b0;
    s_err <= 1'b0;
    if (mst_cyc_o && mst_stb_o && !s_ack && !s_err) begin
      if (mode == 0) begin
        if (mst_we_o) s_err <= 1'b1;
        else          s_ack <= 1'b1;
      end else if (mode == 1) begin
        s_ack <= 1'b1;
        s_err <= 1'b1;
      end
    end
  end
  assign mst_ack_i = s_ack;
  assign mst_err_i = s_err;
  assign mst_dat_i = rom_f(mst_adr_o);

  // Drive a request just after a falling edge; accept happens at the next rising edge.
  task automatic drive_req(input logic we, input logic [63:0] adr, input logic [63:0] dat);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_adr_i   = adr;
    req_dat_i   = dat;
    req_sel_i   = 8'hff;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (req_ready_o !== 1'b1 && k < 30) begin
      @(negedge clk_i);
      k++;
    end
    n_chk++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_idle: req_ready_o=%b required 1 within 30 cycles", req_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    n_chk++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, mst_cyc_o, mst_stb_o, mst_we_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctl: rdy,vld,err,cyc,stb,we=%b required 100000",
               {req_ready_o, rsp_valid_o, rsp_err_o, mst_cyc_o, mst_stb_o, mst_we_o});
    end
    n_chk++;
    if ({rsp_dat_o, mst_adr_o, mst_dat_o, mst_sel_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rsp_dat=%h adr=%h dat=%h sel=%h required all 0",
               rsp_dat_o, mst_adr_o, mst_dat_o, mst_sel_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_read();
    mode = 0;
    drive_req(1'b0, 64'h0, 64'h0);
    @(negedge clk_i); // cycle 1
    req_valid_i = 1'b0;
    n_chk++;
    if ({mst_cyc_o, mst_stb_o, req_ready_o, mst_we_o} !== 4'b1100 || mst_adr_o !== 64'h0) begin
      n_fail++;
      $display("FAIL read_c1: cyc,stb,rdy,we=%b adr=%h required 1100 adr 0",
               {mst_cyc_o, mst_stb_o, req_ready_o, mst_we_o}, mst_adr_o);
    end
    @(negedge clk_i); // cycle 2
    n_chk++;
    if ({mst_stb_o, rsp_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL read_c2: stb,rsp_valid=%b required 10", {mst_stb_o, rsp_valid_o});
    end
    @(negedge clk_i); // cycle 3
    n_chk++;
    if ({rsp_valid_o, rsp_err_o, mst_cyc_o, mst_stb_o, req_ready_o} !== 5'b10000 ||
        rsp_dat_o !== 64'h0280401002000010) begin
      n_fail++;
      $display("FAIL read_c3: vld,err,cyc,stb,rdy=%b dat=%h required 10000 dat 0280401002000010",
               {rsp_valid_o, rsp_err_o, mst_cyc_o, mst_stb_o, req_ready_o}, rsp_dat_o);
    end
    @(negedge clk_i); // cycle 4
    n_chk++;
    if ({rsp_valid_o, req_ready_o, mst_stb_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL read_c4: vld,rdy,stb=%b required 010", {rsp_valid_o, req_ready_o, mst_stb_o});
    end
  endtask

  task automatic test_write_err();
    mode = 0;
    wait_idle();
    drive_req(1'b1, 64'h8, 64'h1234);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n_chk++;
    if ({mst_we_o, mst_stb_o} !== 2'b11 || mst_dat_o !== 64'h1234 || mst_adr_o !== 64'h8 ||
        mst_sel_o !== 8'hff) begin
      n_fail++;
      $display("FAIL write_bus: we,stb=%b dat=%h adr=%h sel=%h required 11 1234 8 ff",
               {mst_we_o, mst_stb_o}, mst_dat_o, mst_adr_o, mst_sel_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if ({rsp_valid_o, rsp_err_o, mst_cyc_o, mst_stb_o} !== 4'b1100 || rsp_dat_o !== 64'h0) begin
      n_fail++;
      $display("FAIL write_err: vld,err,cyc,stb=%b dat=%h required 1100 dat 0",
               {rsp_valid_o, rsp_err_o, mst_cyc_o, mst_stb_o}, rsp_dat_o);
    end
  endtask

  task automatic test_back_to_back();
    int a1 = -1, a2 = -1, nrsp = 0;
    logic [63:0] d [2];
    logic stb_h [0:19];
    mode = 0;
    wait_idle();
    d[0] = '0;
    d[1] = '0;
    drive_req(1'b0, 64'h8, 64'h0);
    for (int i = 0; i < 20; i++) begin
      stb_h[i] = mst_stb_o;
      if (rsp_valid_o === 1'b1) begin
        if (nrsp < 2) d[nrsp] = rsp_dat_o;
        nrsp++;
      end
      if (req_ready_o === 1'b1 && req_valid_i === 1'b1) begin
        if (a1 < 0) a1 = i;
        else if (a2 < 0) a2 = i;
      end
      if (a1 >= 0 && i == a1 + 1) req_adr_i = 64'h10;
      if (a2 >= 0 && i == a2 + 1) req_valid_i = 1'b0;
      @(negedge clk_i);
    end
    n_chk++;
    if (a2 - a1 !== 4 || a1 !== 0) begin
      n_fail++;
      $display("FAIL b2b_accept: accepts at %0d,%0d required 0,4", a1, a2);
    end
    n_chk++;
    if (nrsp !== 2 || d[0] !== 64'h0280800000000e60 || d[1] !== 64'h0281000000000060) begin
      n_fail++;
      $display("FAIL b2b_data: n=%0d d0=%h d1=%h required 2 0280800000000e60 0281000000000060",
               nrsp, d[0], d[1]);
    end
    n_chk++;
    if (a2 < 1 || stb_h[a2] !== 1'b0 || stb_h[a2-1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: stb low gap before second accept missing (a2=%0d)", a2);
    end
  endtask

  task automatic test_misaligned();
    logic seen_cyc = 1'b0;
    mode = 0;
    wait_idle();
    drive_req(1'b0, 64'h4, 64'h0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      if (mst_cyc_o !== 1'b0 || mst_stb_o !== 1'b0) seen_cyc = 1'b1;
      if (i == 1) begin
        n_chk++;
        if ({rsp_valid_o, rsp_err_o, req_ready_o} !== 3'b110 || rsp_dat_o !== 64'h0) begin
          n_fail++;
          $display("FAIL misaligned_rsp: vld,err,rdy=%b dat=%h required 110 dat 0",
                   {rsp_valid_o, rsp_err_o, req_ready_o}, rsp_dat_o);
        end
      end
      if (i == 2) begin
        n_chk++;
        if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
          n_fail++;
          $display("FAIL misaligned_recover: vld,rdy=%b required 01", {rsp_valid_o, req_ready_o});
        end
      end
    end
    n_chk++;
    if (seen_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_nobus: cyc/stb seen=%b required 0", seen_cyc);
    end
  endtask

  task automatic test_ack_err();
    mode = 1;
    wait_idle();
    drive_req(1'b0, 64'h0, 64'h0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if ({rsp_valid_o, rsp_err_o, mst_stb_o} !== 3'b110 || rsp_dat_o !== 64'h0) begin
      n_fail++;
      $display("FAIL ack_err_prio: vld,err,stb=%b dat=%h required 110 dat 0",
               {rsp_valid_o, rsp_err_o, mst_stb_o}, rsp_dat_o);
    end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    logic seen_rsp = 1'b0;
    mode = 2;
    wait_idle();
    drive_req(1'b0, 64'h0, 64'h0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n_chk++;
    if (mst_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: stb=%b required 1", mst_stb_o);
    end
    rst_i = 1'b1;
    #1;
    n_chk++;
    if ({mst_cyc_o, mst_stb_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_async: cyc,stb=%b required 00", {mst_cyc_o, mst_stb_o});
    end
    mode = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (i == 2) rst_i = 1'b0;
      if (rsp_valid_o !== 1'b0) seen_rsp = 1'b1;
    end
    n_chk++;
    if (seen_rsp !== 1'b0 || req_ready_o !== 1'b1 || mst_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_norsp: seen_rsp=%b rdy=%b stb=%b required 0 1 0",
               seen_rsp, req_ready_o, mst_stb_o);
    end
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int rc = -1;
    logic stb_after = 1'b0;
    mode = 2;
    wait_idle();
    drive_req(1'b0, 64'h0, 64'h0);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      if (rc >= 0 && mst_stb_o !== 1'b0) stb_after = 1'b1;
      if (rc < 0 && rsp_valid_o === 1'b1) begin
        rc = i;
        n_chk++;
        if ({rsp_err_o, rsp_timeout_o, mst_stb_o} !== 3'b110 || rsp_dat_o !== 64'h0) begin
          n_fail++;
          $display("FAIL timeout_rsp: err,to,stb=%b dat=%h required 110 dat 0",
                   {rsp_err_o, rsp_timeout_o, mst_stb_o}, rsp_dat_o);
        end
      end
    end
    n_chk++;
    if (rc !== 18 || stb_after !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_cycle: rsp cycle=%0d stb_after=%b required 18 0", rc, stb_after);
    end
    mode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_err();
    test_back_to_back();
    test_misaligned();
    test_ack_err();
    test_reset_mid();
`ifdef WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_master.md
Name: wb_master

Overview:
- Single-outstanding Wishbone classic-cycle master: the initiator end of the bus that slaves such as the instruction ROM respond to.
- Accepts one read or write request from a core-side port (fetch or load/store unit) and runs one bus cycle.
- Returns read data or an error on a response strobe.
- Enforces the stb-low recovery gap the team's slaves need between cycles.

Parameters:
- ADR_WIDTH, 64, bus address width.
- DAT_WIDTH, 64, bus data width (matches `DAT_WIDTH).
- GRANULE, 8, select granularity in bits; SEL_WIDTH = DAT_WIDTH/GRANULE.
- TIMEOUT, 255, max cycles waiting for ack/err; used only with the optional feature; 8-bit counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  core request strobe
- req_ready_o  out  1  master can accept a request this cycle
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  ADR_WIDTH  byte address
- req_dat_i  in  DAT_WIDTH  write data
- req_sel_i  in  SEL_WIDTH  byte-lane select
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  DAT_WIDTH  read data, valid with rsp_valid_o
- rsp_err_o  out  1  error flag, valid with rsp_valid_o
- mst_adr_o  out  ADR_WIDTH  Wishbone address
- mst_dat_o  out  DAT_WIDTH  Wishbone write data
- mst_dat_i  in  DAT_WIDTH  Wishbone read data
- mst_we_o  out  1  Wishbone write enable
- mst_sel_o  out  SEL_WIDTH  Wishbone select
- mst_cyc_o  out  1  Wishbone cycle
- mst_stb_o  out  1  Wishbone strobe
- mst_ack_i  in  1  Wishbone ack
- mst_err_i  in  1  Wishbone error

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, cyc/stb/we=0, adr/dat/sel=0.
- IDLE:
  - req_ready_o=1.
  - Handshake on req_valid_i & req_ready_o.
  - Misaligned request (adr[log2(DAT_WIDTH/8)-1:0] != 0): no bus cycle; next cycle rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0; go RECOVER.
  - Aligned request: latch adr/dat/we/sel; next cycle cyc=stb=1; go BUS; req_ready_o=0.
- BUS:
  - cyc, stb, adr, we, sel, dat held stable until termination.
  - err_i sampled high (takes priority over simultaneous ack_i): next cycle rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0.
  - ack_i sampled high (err_i low): next cycle rsp_valid_o=1, rsp_err_o=0; rsp_dat_o=mst_dat_i for reads, 0 for writes.
  - On either termination: cyc=stb=0 in the same cycle as rsp_valid_o; go RECOVER.
- RECOVER:
  - Exactly one cycle with cyc=stb=0 and req_ready_o=0, then IDLE.
  - Guarantees the slave sees stb low at least one full clock before the next cycle.
- Latency, aligned read against a one-cycle-ack slave:
  - request accepted at edge 0, stb high in cycle 1, ack in cycle 2, rsp_valid_o in cycle 3, req_ready_o high again in cycle 4.
- Back-to-back throughput: one transaction per 4 cycles minimum.
- rsp_valid_o is always a single-cycle pulse. Exactly one response per accepted request.
- req_valid_i while req_ready_o=0 is ignored; the core must hold it.
- Reset mid-operation: cyc/stb drop asynchronously; no response is issued for the aborted request.
- ack_i/err_i while not in BUS are ignored.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - 8-bit counter, cleared on entry to BUS and incremented each BUS cycle.
  - If it reaches TIMEOUT with no ack_i/err_i: terminate as an error (rsp_err_o=1, rsp_dat_o=0, cyc/stb drop), then RECOVER.
  - Extra output rsp_timeout_o, 1 bit, reset 0, pulses with rsp_valid_o only on a timeout termination.
- Undefined: no counter, no rsp_timeout_o port; BUS waits indefinitely.

Test Plan:
- Read adr 0x0000 from instruction ROM -> rsp_valid_o in cycle 3 after accept, rsp_dat_o=0x0280401002000010, rsp_err_o=0; stb high exactly cycles 1-2.
- Write adr 0x0008, dat 0x1234 to ROM -> ROM asserts err; rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0; cyc/stb low the same cycle.
- Reads at 0x0008 then 0x0010 back-to-back, req_valid_i held high -> data 0x0280800000000e60 then 0x0281000000000060; stb low for at least 1 cycle between; second accept 4 cycles after the first.
- Misaligned read at 0x0004 -> no cyc/stb at any point; rsp_valid_o with rsp_err_o=1 one cycle after accept.
- Slave drives ack_i=1 and err_i=1 together -> rsp_err_o=1, rsp_dat_o=0; assert rst_i while in BUS -> cyc/stb low before the next clock edge, no rsp_valid_o.
- With WB_MASTER_TIMEOUT_EN, TIMEOUT=16, silent slave -> rsp_valid_o, rsp_err_o and rsp_timeout_o all 1 exactly 17 cycles after stb rises; stb low from then on.
